axis_slice_24to8: RTL and testbench



---
 rtl/axis_slice_24to8.sv | 76 +++++++
 tb/tb_axis_slice_24to8.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/axis_slice_24to8.sv
// axis_slice_24to8
// Splits each 24-bit AXI-Stream input word into three 8-bit output beats,
// sent LSB first (byte0 = [7:0], then [15:8], then [23:16]).
//
// Ports
//   i_CLK         rising-edge clock
//   i_RSTn        synchronous reset, active HIGH despite the suffix
//   S_AXIS_DATA   24-bit input word
//   S_AXIS_VALID  input word valid
//   S_AXIS_READY  block can take an input word this cycle
//   M_AXIS_DATA   current output byte (0x00 when empty)
//   M_AXIS_VALID  output byte valid
//   M_AXIS_READY  downstream accepts the byte this cycle
module axis_slice_24to8 (
  input  logic        i_CLK,
  input  logic        i_RSTn,
  input  logic [23:0] S_AXIS_DATA,
  input  logic        S_AXIS_VALID,
  output logic        S_AXIS_READY,
  output logic [7:0]  M_AXIS_DATA,
  output logic        M_AXIS_VALID,
  input  logic        M_AXIS_READY
);

  logic [23:0] r_word;
  logic [1:0]  r_idx;
  logic        r_full;

  logic        w_last;
  logic        w_in_xfer;
  logic        w_out_xfer;

  assign w_last = (r_idx == 2'd2);

  // Ready looks through to M_AXIS_READY while the last byte is on the bus,
  // so a new word can replace the finishing one with no idle cycle.
  assign S_AXIS_READY = !i_RSTn && (!r_full || (w_last && M_AXIS_READY));

  assign w_in_xfer  = S_AXIS_VALID && S_AXIS_READY;
  assign w_out_xfer = r_full && M_AXIS_READY;

  assign M_AXIS_VALID = r_full;

  always_comb begin
    M_AXIS_DATA = 8'h00;
    if (r_full) begin
      case (r_idx)
        2'd0:    M_AXIS_DATA = r_word[7:0];
        2'd1:    M_AXIS_DATA = r_word[15:8];
        2'd2:    M_AXIS_DATA = r_word[23:16];
        default: M_AXIS_DATA = 8'h00;
      endcase
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RSTn) begin
      r_word <= 24'h0;
      r_idx  <= 2'd0;
      r_full <= 1'b0;
    end else if (w_in_xfer) begin
      // Only possible when empty or while byte2 is leaving.
      r_word <= S_AXIS_DATA;
      r_idx  <= 2'd0;
      r_full <= 1'b1;
    end else if (w_out_xfer) begin
      if (w_last) begin
        r_idx  <= 2'd0;
        r_full <= 1'b0;
      end else begin
        r_idx  <= r_idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_axis_slice_24to8.sv
// Self-checking bench for axis_slice_24to8. The reference model is a byte
// queue: an accepted word appends its three bytes LSB first, every accepted
// output byte pops the head. Valid/ready/data expectations follow from the
// queue occupancy alone.
module tb_axis_slice_24to8;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;

  always #5 clk = ~clk;

  axis_slice_24to8 dut (
    .i_CLK        (clk),
    .i_RSTn       (rst),
    .S_AXIS_DATA  (s_data),
    .S_AXIS_VALID (s_valid),
    .S_AXIS_READY (s_ready),
    .M_AXIS_DATA  (m_data),
    .M_AXIS_VALID (m_valid),
    .M_AXIS_READY (m_ready)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mq[$];   // model: bytes still owed downstream
  logic [7:0] got[$];  // bytes the DUT actually handed off
  logic       last_in;
  int         n_sready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check #1 later, update model at posedge.
  task automatic cyc(input logic r, input logic sv, input logic [23:0] sd, input logic mr);
    logic e_sready, e_mvalid;
    logic [7:0] e_mdata;
    rst = r; s_valid = sv; s_data = sd; m_ready = mr;
    #1;
    e_mvalid = (mq.size() > 0);
    e_mdata  = e_mvalid ? mq[0] : 8'h00;
    e_sready = !r && (mq.size() == 0 || (mq.size() == 1 && mr));
    chk("m_valid", {31'd0, m_valid}, {31'd0, e_mvalid});
    chk("m_data",  {24'd0, m_data},  {24'd0, e_mdata});
    chk("s_ready", {31'd0, s_ready}, {31'd0, e_sready});
    if (s_ready) n_sready++;
    if (m_valid && mr) got.push_back(m_data);
    last_in = sv && e_sready;
    @(posedge clk);
    if (r) mq.delete();
    else begin
      if (e_mvalid && mr) void'(mq.pop_front());
      if (last_in) begin
        mq.push_back(sd[7:0]);
        mq.push_back(sd[15:8]);
        mq.push_back(sd[23:16]);
      end
    end
    @(negedge clk);
  endtask

  task automatic chk_seq(input string tag, input logic [7:0] e[$]);
    chk({tag, "_len"}, got.size(), e.size());
    for (int i = 0; i < e.size() && i < got.size(); i++)
      chk(tag, {24'd0, got[i]}, {24'd0, e[i]});
    got.delete();
  endtask

  initial begin
    logic [7:0]  e[$];
    logic [23:0] words[10];
    int w;

    // Bring registers out of X before checking anything.
    rst = 1'b1; s_valid = 1'b1; s_data = 24'hFFFFFF; m_ready = 1'b1;
    @(posedge clk); @(negedge clk);

    // Reset held with a valid word offered: nothing captured.
    cyc(1, 1, 24'h5A5A5A, 1);
    cyc(1, 1, 24'h5A5A5A, 1);
    cyc(0, 0, 24'h0, 1);                 // s_ready must be 1 right after release
    chk_seq("reset", e);

    // Single word.
    cyc(0, 1, 24'hA1B2C3, 1);
    repeat (4) cyc(0, 0, 24'h0, 1);
    e = {8'hC3, 8'hB2, 8'hA1};
    chk_seq("single", e);

    // Streaming: 10 words back to back.
    for (int i = 0; i < 10; i++) words[i] = $urandom();
    w = 0; n_sready = 0; e.delete();
    for (int i = 0; i < 10; i++) begin
      e.push_back(words[i][7:0]); e.push_back(words[i][15:8]); e.push_back(words[i][23:16]);
    end
    for (int c = 0; c < 31; c++) begin
      cyc(0, w < 10, w < 10 ? words[w] : 24'h0, 1);
      if (last_in) w++;
    end
    chk("stream_ready_cnt", n_sready, 11);  // 10 accepts + the now-empty final cycle
    chk_seq("stream", e);

    // Back-pressure on byte1.
    cyc(0, 1, 24'h112233, 1);
    cyc(0, 0, 24'h0, 1);
    repeat (4) cyc(0, 1, 24'h998877, 0);
    repeat (3) cyc(0, 0, 24'h0, 1);
    e = {8'h33, 8'h22, 8'h11};
    chk_seq("bp", e);

    // Random traffic then drain.
    e.delete();
    for (int c = 0; c < 30; c++) begin
      logic [23:0] d;
      d = $urandom();
      cyc(0, $urandom_range(0, 1), d, $urandom_range(0, 1));
      if (last_in) begin
        e.push_back(d[7:0]); e.push_back(d[15:8]); e.push_back(d[23:16]);
      end
    end
    repeat (20) cyc(0, 0, 24'h0, 1);
    chk("rand_empty", mq.size(), 0);
    chk_seq("rand", e);
    cyc(0, 1, 24'hCAFE01, 1);
    cyc(0, 0, 24'h0, 1);
    cyc(0, 0, 24'h0, 1);
    cyc(0, 1, 24'h0BEEF0, 1);
    repeat (4) cyc(0, 0, 24'h0, 1);
    e = {8'h01, 8'hFE, 8'hCA, 8'hF0, 8'hEE, 8'h0B};
    chk_seq("post_rand", e);

    // Reset in the middle of a word.
    cyc(0, 1, 24'hDEADBE, 1);
    cyc(0, 0, 24'h0, 1);                 // byte0 0xBE leaves
    cyc(1, 0, 24'h0, 0);                 // reset, downstream stalled
    cyc(0, 1, 24'h123456, 1);
    repeat (4) cyc(0, 0, 24'h0, 1);
    e = {8'hBE, 8'h56, 8'h34, 8'h12};
    chk_seq("midreset", e);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
